// File: rtl/pwm_capture_if.sv
// pwm_capture_if
//   Groups the PWM capture signals into one bundle.
//   pwm_in : raw (asynchronous) PWM waveform into the capture block
//   duty   : last measured duty word (high clocks per frame)
//   valid  : one-cycle pulse, duty was just updated
//   err    : one-cycle pulse, a frame was rejected for bad length
//   locked : high while the capture block is tracking frames
//   master : the capture block (consumes pwm_in, produces the samples)
//   slave  : whoever drives the waveform and consumes the samples
interface pwm_capture_if #(
  parameter int WIDTH = 8
) ();
  logic             pwm_in;
  logic [WIDTH-1:0] duty;
  logic             valid;
  logic             err;
  logic             locked;

  modport master (
    input  pwm_in,
    output duty,
    output valid,
    output err,
    output locked
  );

  modport slave (
    output pwm_in,
    input  duty,
    input  valid,
    input  err,
    input  locked
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures the high time of each PWM frame (rise to rise) on an
//   asynchronous input and reports it as a duty word. Frames of the wrong
//   length are flagged, and a stuck input is reported as a constant level
//   every 2*PERIOD clocks.
//   clk : system clock
//   rst : asynchronous, active-low reset
//   bus : pwm_capture_if master modport (pwm_in in; duty/valid/err/locked out)
//   WIDTH : duty word width, nominal frame length is 2**WIDTH clocks
//   TOL   : accepted frame length deviation in clocks (+/-)
module pwm_capture #(
  parameter int WIDTH = 8,
  parameter int TOL   = 0
) (
  input  logic           clk,
  input  logic           rst,
  pwm_capture_if.master  bus
);

  // Counters are two bits wider than the duty word so they can hold 2*PERIOD.
  localparam int CW       = WIDTH + 2;
  localparam int PERIOD_I = 1 << WIDTH;

  localparam logic [CW-1:0]    MIN_LEN      = CW'(PERIOD_I - TOL);
  localparam logic [CW-1:0]    MAX_LEN      = CW'(PERIOD_I + TOL);
  localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(2 * PERIOD_I - 1);
  localparam logic [CW-1:0]    SAT_CNT      = CW'(PERIOD_I - 1);
  localparam logic [WIDTH-1:0] DUTY_MAX     = {WIDTH{1'b1}};

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t           state, state_next;
  logic             sync1, s, s_d;
  logic [CW-1:0]    per_cnt, per_next;
  logic [CW-1:0]    hi_cnt, hi_next;
  logic [WIDTH-1:0] duty_q, duty_next;
  logic             valid_q, valid_next;
  logic             err_q, err_next;
  logic             locked_q, locked_next;
  logic             rise;

  assign rise = s & ~s_d;

  // State, synchronizer and every output are plain registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b0;
      s        <= 1'b0;
      s_d      <= 1'b0;
      state    <= IDLE;
      per_cnt  <= '0;
      hi_cnt   <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      sync1    <= bus.pwm_in;
      s        <= sync1;
      s_d      <= s;
      state    <= state_next;
      per_cnt  <= per_next;
      hi_cnt   <= hi_next;
      duty_q   <= duty_next;
      valid_q  <= valid_next;
      err_q    <= err_next;
      locked_q <= locked_next;
    end
  end

  // A rise always wins over the timeout in the same cycle. The first rise
  // out of IDLE only opens a frame; later rises close one and judge its length.
  always_comb begin
    state_next = state;
    per_next   = per_cnt;
    hi_next    = hi_cnt;
    duty_next  = duty_q;
    valid_next = 1'b0;
    err_next   = 1'b0;

    if (rise) begin
      per_next   = CW'(1);
      hi_next    = CW'(1);
      state_next = MEASURE;
      if (state == MEASURE) begin
        if (per_cnt >= MIN_LEN && per_cnt <= MAX_LEN) begin
          duty_next  = (hi_cnt > SAT_CNT) ? DUTY_MAX : hi_cnt[WIDTH-1:0];
          valid_next = 1'b1;
        end else begin
          err_next = 1'b1;
        end
      end
    end else if (per_cnt == TIMEOUT_LAST) begin
      // No edge for 2*PERIOD clocks: report the current level as a constant.
      duty_next  = s ? DUTY_MAX : '0;
      valid_next = 1'b1;
      per_next   = '0;
      hi_next    = '0;
      state_next = IDLE;
    end else begin
      per_next = per_cnt + CW'(1);
      if (state == MEASURE) begin
        hi_next = hi_cnt + CW'(s);
      end
    end

    locked_next = (state_next == MEASURE);
  end

  assign bus.duty   = duty_q;
  assign bus.valid  = valid_q;
  assign bus.err    = err_q;
  assign bus.locked = locked_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
//   Drives one randomized PWM waveform into two capture blocks (TOL=0 and
//   TOL=2) and compares every output each cycle against a timestamp based
//   reference model: frames are measured as the distance between rise edges
//   of the synchronized waveform and duty as the number of high samples.
module tb_pwm_capture;

  localparam int WIDTH  = 8;
  localparam int PERIOD = 1 << WIDTH;
  localparam int DMAX   = PERIOD - 1;
  localparam int HMAX   = 40000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pwm = 1'b0;

  always #5 clk = ~clk;

  pwm_capture_if #(.WIDTH(WIDTH)) bus0 ();
  pwm_capture_if #(.WIDTH(WIDTH)) bus1 ();

  assign bus0.pwm_in = pwm;
  assign bus1.pwm_in = pwm;

  pwm_capture #(.WIDTH(WIDTH), .TOL(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  pwm_capture #(.WIDTH(WIDTH), .TOL(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  int total = 0;
  int bad   = 0;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model state: waveform history per clock edge and, per
  // instance, the edge index of the last frame-opening rise and the edge
  // from which the no-edge timeout is measured.
  bit hist [HMAX];
  int edge_cnt = 0;
  int tol_of [2] = '{0, 2};
  bit m_locked [2] = '{1'b0, 1'b0};
  int rise_edge [2] = '{0, 0};
  int origin [2] = '{0, 0};
  int exp_duty [2] = '{0, 0};
  bit exp_valid [2] = '{1'b0, 1'b0};
  bit exp_err [2] = '{1'b0, 1'b0};

  function automatic bit h(input int idx);
    if (idx < 0 || idx >= HMAX) return 1'b0;
    return hist[idx];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_locked[i]  = 1'b0;
      exp_duty[i]  = 0;
      exp_valid[i] = 1'b0;
      exp_err[i]   = 1'b0;
      origin[i]    = edge_cnt;
    end
  endfunction

  // Reset clears the synchronizer at once, so recent history reads as low.
  always @(negedge rst) begin
    for (int j = 0; j < 3; j++)
      if (edge_cnt - j >= 0 && edge_cnt - j < HMAX) hist[edge_cnt - j] = 1'b0;
    model_reset();
  end

  // The synchronized level seen at edge e is the input sampled at edge e-2.
  always @(posedge clk) begin
    int  e, len, hi;
    bit  sv, svd, rise;
    edge_cnt = edge_cnt + 1;
    e = edge_cnt;
    if (!rst) begin
      if (e < HMAX) hist[e] = 1'b0;
      model_reset();
    end else begin
      if (e < HMAX) hist[e] = pwm;
      sv   = h(e - 2);
      svd  = h(e - 3);
      rise = sv & ~svd;
      for (int i = 0; i < 2; i++) begin
        exp_valid[i] = 1'b0;
        exp_err[i]   = 1'b0;
        if (rise) begin
          if (m_locked[i]) begin
            len = e - rise_edge[i];
            if (len >= PERIOD - tol_of[i] && len <= PERIOD + tol_of[i]) begin
              hi = 0;
              for (int j = rise_edge[i] - 2; j <= e - 3; j++) hi += int'(h(j));
              exp_duty[i]  = (hi > DMAX) ? DMAX : hi;
              exp_valid[i] = 1'b1;
            end else begin
              exp_err[i] = 1'b1;
            end
          end
          m_locked[i]  = 1'b1;
          rise_edge[i] = e;
          origin[i]    = e - 1;
        end else if (e - origin[i] == 2 * PERIOD) begin
          exp_duty[i]  = sv ? DMAX : 0;
          exp_valid[i] = 1'b1;
          m_locked[i]  = 1'b0;
          origin[i]    = e;
        end
      end
    end
  end

  // Outputs are compared mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    checkOutput("duty0",   bus0.duty,   exp_duty[0]);
    checkOutput("valid0",  bus0.valid,  exp_valid[0]);
    checkOutput("err0",    bus0.err,    exp_err[0]);
    checkOutput("locked0", bus0.locked, m_locked[0]);
    checkOutput("excl0",   bus0.valid & bus0.err, 0);
    checkOutput("duty1",   bus1.duty,   exp_duty[1]);
    checkOutput("valid1",  bus1.valid,  exp_valid[1]);
    checkOutput("err1",    bus1.err,    exp_err[1]);
    checkOutput("locked1", bus1.locked, m_locked[1]);
    checkOutput("excl1",   bus1.valid & bus1.err, 0);
  end

  task automatic drive_cycles(input bit level, input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      pwm = level;
    end
  endtask

  // One PWM frame: high for 'high' clocks, then low for the rest.
  task automatic applyStimulus(input int period, input int high);
    drive_cycles(1'b1, high);
    drive_cycles(1'b0, period - high);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_duty"},   bus0.duty,   0);
    checkOutput({tag, "_valid"},  bus0.valid,  0);
    checkOutput({tag, "_err"},    bus0.err,    0);
    checkOutput({tag, "_locked"}, bus0.locked, 0);
  endtask

  initial begin
    int r, per, hig;
    #1;
    check_reset_outputs("por");
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;

    // Stuck low from reset, then stuck high.
    drive_cycles(1'b0, 1100);
    drive_cycles(1'b1, 600);
    drive_cycles(1'b0, 10);

    // Nominal and extreme duty.
    repeat (4) applyStimulus(256, 128);
    repeat (3) applyStimulus(256, 1);
    repeat (3) applyStimulus(256, 255);

    // Short frame between good ones, then frames inside TOL=2 only.
    repeat (3) applyStimulus(256, 100);
    applyStimulus(200, 100);
    repeat (2) applyStimulus(256, 100);
    repeat (2) applyStimulus(258, 100);
    applyStimulus(254, 100);
    repeat (2) applyStimulus(256, 100);
    applyStimulus(258, 257);
    applyStimulus(256, 30);

    // Randomized frames, mostly nominal length.
    repeat (30) begin
      r = $urandom_range(0, 9);
      if (r < 7)      per = 256;
      else if (r < 9) per = $urandom_range(254, 258);
      else            per = $urandom_range(150, 300);
      hig = $urandom_range(1, per - 1);
      applyStimulus(per, hig);
    end

    // Glitch inside a frame restarts it.
    repeat (3) applyStimulus(256, 100);
    drive_cycles(1'b1, 100);
    drive_cycles(1'b0, 50);
    drive_cycles(1'b1, 1);
    drive_cycles(1'b0, 105);
    repeat (3) applyStimulus(256, 100);

    // Reset at clock 100 of a frame while locked at duty 64.
    repeat (4) applyStimulus(256, 64);
    drive_cycles(1'b1, 64);
    drive_cycles(1'b0, 36);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    drive_cycles(1'b0, 4);
    @(posedge clk);
    #2;
    rst = 1'b1;
    pwm = 1'b0;
    repeat (4) applyStimulus(256, 64);

    drive_cycles(1'b0, 600);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
